// File: rtl/comp_sched.sv
// Purpose: round-robin scheduler sharing one unsigned magnitude comparator between NREQ requesters.
// Latency: grant at edge T, registered E/G/L result at edge T+1; one compare per 3 cycles at most.
// Backpressure: requesters hold req with stable operands until gnt; no grant while a compare is in flight.
//
// Ports: clk/rst (sync active-high); req, a_in, b_in from requesters (requester i at [i*WIDTH +: WIDTH]);
//        gnt one-hot grant pulse; busy while CMP/DONE; res_valid pulse with res_id and E/G/L.
// Optional: define COMP_SCHED_COUNT_EN to add cmp_count[15:0], a saturating completed-compare counter.
module comp_sched #(
    parameter int WIDTH = 12,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic                  E,
    output logic                  G,
    output logic                  L
`ifdef COMP_SCHED_COUNT_EN
    ,
    output logic [15:0]           cmp_count
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cur_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW:0]     idx_w;

    // Rotating priority search starting at ptr. The loop runs from the
    // farthest candidate back to ptr so the nearest requester is assigned last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_w     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr} + (IDW+1)'(k);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            if (req[idx_w[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_w[IDW-1:0];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            E         <= 1'b0;
            G         <= 1'b0;
            L         <= 1'b0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt[win_idx] <= 1'b1;
                        op_a         <= a_in[int'(win_idx)*WIDTH +: WIDTH];
                        op_b         <= b_in[int'(win_idx)*WIDTH +: WIDTH];
                        cur_id       <= win_idx;
                        ptr          <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        state        <= CMP;
                    end
                end
                CMP: begin
                    // Captured operands only: requester inputs may already have moved on.
                    G         <= (op_a > op_b);
                    E         <= (op_a == op_b);
                    L         <= (op_a < op_b);
                    res_id    <= cur_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COMP_SCHED_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_count <= '0;
        end else if (res_valid && (cmp_count != 16'hFFFF)) begin
            cmp_count <= cmp_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_comp_sched.sv
module tb_comp_sched;

    localparam int WIDTH = 12;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic                  E, G, L;
`ifdef COMP_SCHED_COUNT_EN
    logic [15:0]           cmp_count;
`endif

    comp_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .E         (E),
        .G         (G),
        .L         (L)
`ifdef COMP_SCHED_COUNT_EN
        ,
        .cmp_count (cmp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: a compare occupies 3 cycles after its grant; between compares the
    // next winner is the first requester at or after the rotating pointer.
    int              m_age;   // edges since last grant (0 = idle)
    int              m_ptr;
    int              m_id;
    int              m_a, m_b;
    logic [NREQ-1:0] x_gnt;
    logic            x_busy, x_vld;
    int              x_id;
    logic            x_e, x_g, x_l;
    int              m_cnt;

    int              grant_log[$];
    logic [4:0]      res_log[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_age = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0; m_cnt = 0;
            x_gnt = '0; x_busy = 0; x_vld = 0; x_id = 0; x_e = 0; x_g = 0; x_l = 0;
        end else begin
            if (x_vld && m_cnt != 16'hFFFF) m_cnt++;
            x_gnt = '0;
            x_vld = 0;
            if (m_age == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int w;
                    w = (m_ptr + k) % NREQ;
                    if (req[w] && m_age == 0) begin
                        x_gnt[w] = 1'b1;
                        m_id  = w;
                        m_a   = int'(a_in[w*WIDTH +: WIDTH]);
                        m_b   = int'(b_in[w*WIDTH +: WIDTH]);
                        m_ptr = (w + 1) % NREQ;
                        m_age = 1;
                    end
                end
            end else if (m_age == 1) begin
                x_vld = 1; x_id = m_id;
                x_g = (m_a > m_b); x_e = (m_a == m_b); x_l = (m_a < m_b);
                m_age = 2;
            end else begin
                m_age = 0;
            end
            x_busy = (m_age != 0);
        end
        #1;
        n_vec++;
        if (gnt !== x_gnt || busy !== x_busy || res_valid !== x_vld || res_id !== IDW'(x_id) ||
            E !== x_e || G !== x_g || L !== x_l) begin
            n_err++;
            $display("FAIL cycle %0d outputs: got gnt=%b busy=%b vld=%b id=%0d egl=%b%b%b, want gnt=%b busy=%b vld=%b id=%0d egl=%b%b%b",
                     cyc, gnt, busy, res_valid, res_id, E, G, L, x_gnt, x_busy, x_vld, x_id, x_e, x_g, x_l);
        end
`ifdef COMP_SCHED_COUNT_EN
        n_vec++;
        if (cmp_count !== 16'(m_cnt)) begin
            n_err++;
            $display("FAIL cycle %0d cmp_count: got %0d want %0d", cyc, cmp_count, m_cnt);
        end
`endif
        for (int i = 0; i < NREQ; i++) if (gnt[i]) grant_log.push_back(i);
        if (res_valid) res_log.push_back({res_id, E, G, L});
    end

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    // Hand-derived expectations: {id, E, G, L}
    int         exp_grants[$];
    logic [4:0] exp_res[$];

    initial begin
        exp_grants = '{0, 1, 2, 3, 0, 2, 3, 0};
        exp_res    = '{5'b00_100, 5'b01_001, 5'b10_010, 5'b11_010, 5'b00_100, 5'b10_010, 5'b00_100};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        set_ops(0, 12'hFFF, 12'hFFF);   // equal at top of range
        set_ops(1, 12'h000, 12'hFFF);   // less, extremes
        set_ops(2, 12'h800, 12'h7FF);   // MSB set must read as greater
        set_ops(3, 12'hFFF, 12'h000);   // greater, extremes
        req = 4'b1111;
        repeat (2) @(negedge clk);

        // Continuous requests: rotation 0,1,2,3,0 every 3 cycles
        rst = 1'b0;
        repeat (13) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Single requester; its operands change right after the grant
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        set_ops(2, 12'h000, 12'h7FF);
        repeat (3) @(negedge clk);

        // Reset during the compare abandons it and restarts rotation at 0
        req = 4'b1000;
        @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0; req = 4'b0011;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        check_int("grant_count", grant_log.size(), exp_grants.size());
        for (int i = 0; i < exp_grants.size(); i++)
            check_int($sformatf("grant_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, exp_grants[i]);
        check_int("result_count", res_log.size(), exp_res.size());
        for (int i = 0; i < exp_res.size(); i++)
            check_int($sformatf("result_%0d", i), (i < res_log.size()) ? int'(res_log[i]) : -1, int'(exp_res[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
